// File: rtl/run_ctrl.sv
// Program run sequencer: holds the core in reset, releases it, counts executed cycles
// and ends on the halt PC or on timeout. Optional single-step support under RUN_CTRL_STEP_EN.
module run_ctrl #(
    parameter int D       = 12,
    parameter int CW      = 16,
    parameter int HALT_PC = 128,
    parameter int RST_CYC = 2,
    parameter int MAX_CYC = 60000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
`ifdef RUN_CTRL_STEP_EN
    input  logic          step_mode,
    input  logic          step,
`endif
    input  logic [D-1:0]  prog_ctr,
    output logic          core_rst,
    output logic          core_en,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_cnt
);

    localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [D-1:0]   HALT_PC_V  = D'(HALT_PC);
    localparam logic [CW-1:0]  MAX_V      = CW'(MAX_CYC);
    localparam logic [CW-1:0]  MAX_M1_V   = CW'(MAX_CYC - 1);
    localparam logic [RCW-1:0] RST_LAST_V = RCW'(RST_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state_r;
    state_t         next_s;
    logic [RCW-1:0] rst_cnt_r;
    logic           at_halt_s;
    logic           step_ok_s;
    logic           core_en_s;

`ifdef RUN_CTRL_STEP_EN
    logic step_q_r;
    logic step_pulse_r;

    // Registered rising-edge detector on step; the pulse opens one execute cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q_r     <= 1'b0;
            step_pulse_r <= 1'b0;
        end else begin
            step_q_r     <= step;
            step_pulse_r <= step & ~step_q_r;
        end
    end

    assign step_ok_s = ~step_mode | step_pulse_r;
`else
    assign step_ok_s = 1'b1;
`endif

    assign at_halt_s = (prog_ctr == HALT_PC_V);
    // Combinational so the core freezes in the very cycle the halt PC appears.
    assign core_en_s = (state_r == S_RUN) && !at_halt_s && step_ok_s;
    assign core_en   = core_en_s;

    // Next-state decode.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req) next_s = S_RST;
                else     next_s = S_IDLE;
            end
            S_RST: begin
                if (rst_cnt_r == RST_LAST_V) next_s = S_RUN;
                else                         next_s = S_RST;
            end
            S_RUN: begin
                if (at_halt_s)                                next_s = S_DONE;
                else if (core_en_s && cycle_cnt == MAX_M1_V)  next_s = S_DONE;
                else                                          next_s = S_RUN;
            end
            S_DONE: begin
                if (!req) next_s = S_IDLE;
                else      next_s = S_DONE;
            end
            default: next_s = S_IDLE;
        endcase
    end

    // State, registered status outputs and run counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            rst_cnt_r <= '0;
            core_rst  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state_r  <= next_s;
            core_rst <= (next_s == S_IDLE) || (next_s == S_RST);
            busy     <= (next_s == S_RST) || (next_s == S_RUN);
            done     <= (next_s == S_DONE);
            case (state_r)
                S_IDLE: begin
                    if (req) begin
                        cycle_cnt <= '0;
                        timeout   <= 1'b0;
                        rst_cnt_r <= '0;
                    end
                end
                S_RST: begin
                    if (rst_cnt_r != RST_LAST_V) rst_cnt_r <= rst_cnt_r + {{(RCW-1){1'b0}}, 1'b1};
                end
                S_RUN: begin
                    if (core_en_s) begin
                        if (cycle_cnt == MAX_M1_V) begin
                            cycle_cnt <= MAX_V;
                            timeout   <= 1'b1;
                        end else if (cycle_cnt != MAX_V) begin
                            cycle_cnt <= cycle_cnt + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
